// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and playfield constants for the catching game
package game_pkg;

  localparam int COORD_W = 10;

  localparam logic [COORD_W-1:0] TRAY_Y        = 10'd440;
  localparam logic [COORD_W-1:0] SCREEN_BOTTOM = 10'd479;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_OVER = 2'd2
  } game_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE,
    S_SPAWN,
    S_OVER
  } fsm_state_t;

endpackage

// File: rtl/catch_window.sv
// rtl/catch_window.sv - per-slot fall step and catch/miss decision against the tray
module catch_window
  import game_pkg::*;
#(
  parameter int FALL_STEP = 2,
  parameter int TRAY_HALF = 32,
  parameter int OBJ_HALF  = 8
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] tray_position,
  output logic [COORD_W-1:0] new_y,
  output logic               is_catch,
  output logic               is_miss
);

  localparam logic [COORD_W-1:0] REACH = COORD_W'(TRAY_HALF + OBJ_HALF);
  localparam logic [COORD_W-1:0] STEP  = COORD_W'(FALL_STEP);

  logic [COORD_W:0]   max_sum;
  logic [COORD_W-1:0] tray_min;
  logic [COORD_W-1:0] tray_max;
  logic               in_window;
  logic               crossing;

  always_comb begin
    new_y     = y + STEP;
    // Window edges clamp to the screen instead of wrapping around it.
    max_sum   = {1'b0, tray_position} + {1'b0, REACH};
    tray_min  = (tray_position >= REACH) ? (tray_position - REACH) : '0;
    tray_max  = max_sum[COORD_W] ? '1 : max_sum[COORD_W-1:0];
    in_window = (x >= tray_min) && (x <= tray_max);
    crossing  = (y < TRAY_Y) && (new_y >= TRAY_Y);
    is_catch  = crossing && in_window;
    is_miss   = !is_catch && (new_y >= SCREEN_BOTTOM);
  end

endmodule

// File: rtl/catch_game_scheduler.sv
// rtl/catch_game_scheduler.sv - object slot pool, per-frame sweep, spawn scheduling and scoring
module catch_game_scheduler
  import game_pkg::*;
#(
  parameter int NUM_OBJ        = 4,
  parameter int SPAWN_INTERVAL = 60,
  parameter int FALL_STEP      = 2,
  parameter int X_OFFSET       = 64,
  parameter int TRAY_HALF      = 32,
  parameter int OBJ_HALF       = 8,
  parameter int INIT_LIVES     = 3
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_tick,
  input  logic                       start,
  input  logic [8:0]                 rand_position,
  input  logic [COORD_W-1:0]         tray_position,
  output logic [NUM_OBJ-1:0]         obj_valid,
  output logic [COORD_W*NUM_OBJ-1:0] obj_x,
  output logic [COORD_W*NUM_OBJ-1:0] obj_y,
  output logic [7:0]                 score,
  output logic [1:0]                 lives,
  output logic [1:0]                 game_state,
  output logic                       catch_pulse,
  output logic                       miss_pulse,
  output logic                       overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int CNT_W = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_OBJ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SPAWN_INTERVAL - 1);
  localparam logic [COORD_W-1:0] X_OFF      = COORD_W'(X_OFFSET);
  localparam logic [1:0]         LIVES_INIT = 2'(INIT_LIVES);

  fsm_state_t         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OBJ-1:0] valid_q, valid_d;
  logic [COORD_W-1:0] x_q [NUM_OBJ];
  logic [COORD_W-1:0] x_d [NUM_OBJ];
  logic [COORD_W-1:0] y_q [NUM_OBJ];
  logic [COORD_W-1:0] y_d [NUM_OBJ];
  logic [7:0]         score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               catch_q, catch_d, miss_q, miss_d, overrun_q, overrun_d;

  logic [COORD_W-1:0] cw_new_y;
  logic               cw_catch, cw_miss;
  logic               has_free;
  logic [IDX_W-1:0]   free_idx;

  catch_window #(
    .FALL_STEP(FALL_STEP),
    .TRAY_HALF(TRAY_HALF),
    .OBJ_HALF (OBJ_HALF)
  ) u_window (
    .x            (x_q[idx_q]),
    .y            (y_q[idx_q]),
    .tray_position(tray_position),
    .new_y        (cw_new_y),
    .is_catch     (cw_catch),
    .is_miss      (cw_miss)
  );

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_WAIT;
      S_WAIT:   if (frame_tick) state_d = S_UPDATE;
      S_UPDATE: if (idx_q == IDX_LAST) state_d = S_SPAWN;
      S_SPAWN:  state_d = (lives_q == 2'd0) ? S_OVER : S_WAIT;
      S_OVER:   if (start) state_d = S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    game_state = GS_PLAY;
    if (state_q == S_IDLE) game_state = GS_IDLE;
    if (state_q == S_OVER) game_state = GS_OVER;
    obj_valid = (state_q == S_OVER) ? '0 : valid_q;
    obj_x = '0;
    obj_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      obj_x[COORD_W*i +: COORD_W] = x_q[i];
      obj_y[COORD_W*i +: COORD_W] = y_q[i];
    end
    score       = score_q;
    lives       = lives_q;
    catch_pulse = catch_q;
    miss_pulse  = miss_q;
    overrun     = overrun_q;
  end

  always_comb begin
    idx_d     = idx_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    score_d   = score_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    catch_d   = 1'b0;
    miss_d    = 1'b0;
    overrun_d = frame_tick && ((state_q == S_UPDATE) || (state_q == S_SPAWN));
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          idx_d   = '0;
          valid_d = '0;
          score_d = '0;
          lives_d = LIVES_INIT;
          cnt_d   = '0;
          for (int i = 0; i < NUM_OBJ; i++) begin
            x_d[i] = '0;
            y_d[i] = '0;
          end
        end
      end
      S_WAIT: if (frame_tick) idx_d = '0;
      S_UPDATE: begin
        idx_d = idx_q + 1'b1;
        if (valid_q[idx_q]) begin
          if (cw_catch) begin
            valid_d[idx_q] = 1'b0;
            catch_d        = 1'b1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else if (cw_miss) begin
            valid_d[idx_q] = 1'b0;
            miss_d         = 1'b1;
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
          end else begin
            y_d[idx_q] = cw_new_y;
          end
        end
      end
      S_SPAWN: begin
        // A full pool leaves the counter parked at its last value so the spawn fires on the next free sweep.
        if (lives_q != 2'd0) begin
          if (cnt_q == CNT_LAST) begin
            if (has_free) begin
              valid_d[free_idx] = 1'b1;
              x_d[free_idx]     = {1'b0, rand_position} + X_OFF;
              y_d[free_idx]     = '0;
              cnt_d             = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q     <= '0;
      valid_q   <= '0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      cnt_q     <= '0;
      catch_q   <= 1'b0;
      miss_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      catch_q   <= catch_d;
      miss_q    <= miss_d;
      overrun_q <= overrun_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

endmodule

// File: tb/tb_catch_game_scheduler.sv
// tb/tb_catch_game_scheduler.sv - self-checking bench for catch_game_scheduler
module tb_catch_game_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ft, st, rst1, ft1, st1;
  logic [8:0] rnd, rnd1;
  logic [9:0] tray, tray1;
  logic [3:0] valid, valid1;
  logic [39:0] ox, oy, ox1, oy1;
  logic [7:0] score, score1;
  logic [1:0] lives, lives1, gstate, gstate1;
  logic cpulse, mpulse, ovr, cpulse1, mpulse1, ovr1;

  logic [9:0] cw_x, cw_y, cw_tray, cw_ny;
  logic cw_c, cw_m;

  catch_game_scheduler dut (
    .Clk(clk), .Reset(rst), .frame_tick(ft), .start(st), .rand_position(rnd),
    .tray_position(tray), .obj_valid(valid), .obj_x(ox), .obj_y(oy), .score(score),
    .lives(lives), .game_state(gstate), .catch_pulse(cpulse), .miss_pulse(mpulse),
    .overrun(ovr));

  catch_game_scheduler #(.SPAWN_INTERVAL(1)) dut1 (
    .Clk(clk), .Reset(rst1), .frame_tick(ft1), .start(st1), .rand_position(rnd1),
    .tray_position(tray1), .obj_valid(valid1), .obj_x(ox1), .obj_y(oy1), .score(score1),
    .lives(lives1), .game_state(gstate1), .catch_pulse(cpulse1), .miss_pulse(mpulse1),
    .overrun(ovr1));

  catch_window u_cw (.x(cw_x), .y(cw_y), .tray_position(cw_tray), .new_y(cw_ny),
                     .is_catch(cw_c), .is_miss(cw_m));

  int n_cmp = 0;
  int n_fail = 0;

  int ev_count = 0;
  int obs [0:255];
  int c1 = 0, m1 = 0, o1 = 0, o0 = 0;

  always @(negedge clk) begin
    if (cpulse && ev_count < 256) begin
      obs[ev_count] <= 1;
      ev_count <= ev_count + 1;
    end else if (mpulse && ev_count < 256) begin
      obs[ev_count] <= 0;
      ev_count <= ev_count + 1;
    end
    if (cpulse1) c1 <= c1 + 1;
    if (mpulse1) m1 <= m1 + 1;
    if (ovr1) o1 <= o1 + 1;
    if (ovr) o0 <= o0 + 1;
  end

  localparam int SI = 60;
  int m_v [4];
  int m_x [4];
  int m_y [4];
  int m_score, m_lives, m_state, m_cnt;
  int exp_q [$];
  int rd = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_start();
    if (m_state != 1) begin
      m_state = 1; m_score = 0; m_lives = 3; m_cnt = 0;
      for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    end
  endtask

  task automatic model_sweep(input int r, input int t);
    int tmin, tmax, ny, fs;
    if (m_state != 1) return;
    tmin = (t >= 40) ? t - 40 : 0;
    tmax = (t + 40 > 1023) ? 1023 : t + 40;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] != 0) begin
        ny = m_y[i] + 2;
        if (m_y[i] < 440 && ny >= 440 && m_x[i] >= tmin && m_x[i] <= tmax) begin
          m_v[i] = 0;
          if (m_score < 255) m_score++;
          exp_q.push_back(1);
        end else if (ny >= 479) begin
          m_v[i] = 0;
          if (m_lives > 0) m_lives--;
          exp_q.push_back(0);
        end else begin
          m_y[i] = ny;
        end
      end
    end
    if (m_lives == 0) m_state = 2;
    else if (m_cnt == SI - 1) begin
      fs = -1;
      for (int i = 3; i >= 0; i--) if (m_v[i] == 0) fs = i;
      if (fs >= 0) begin m_v[fs] = 1; m_x[fs] = r + 64; m_y[fs] = 0; m_cnt = 0; end
    end else m_cnt++;
  endtask

  task automatic compare_model();
    logic [39:0] ex, ey;
    logic [3:0] ev;
    ex = '0; ey = '0; ev = '0;
    for (int i = 0; i < 4; i++) begin
      ex[10*i +: 10] = 10'(m_x[i]);
      ey[10*i +: 10] = 10'(m_y[i]);
      ev[i] = (m_v[i] != 0);
    end
    if (m_state == 2) ev = 4'h0;
    check("obj_valid", valid, ev);
    check("obj_x", ox, ex);
    check("obj_y", oy, ey);
    check("score", score, m_score);
    check("lives", lives, m_lives);
    check("game_state", gstate, m_state);
    while (rd < ev_count) begin
      if (exp_q.size() == 0) check("unexpected_event", obs[rd], 2);
      else check("event_kind", obs[rd], exp_q.pop_front());
      rd++;
    end
    check("events_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic tick_main();
    @(posedge clk); #1 ft = 1'b1;
    @(posedge clk); #1 ft = 1'b0;
    model_sweep(int'(rnd), int'(tray));
    repeat (8) @(posedge clk);
    #1 compare_model();
  endtask

  task automatic tick1();
    @(posedge clk); #1 ft1 = 1'b1;
    @(posedge clk); #1 ft1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic start_main();
    @(posedge clk); #1 st = 1'b1;
    @(posedge clk); #1 st = 1'b0;
    model_start();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic start1();
    @(posedge clk); #1 st1 = 1'b1;
    @(posedge clk); #1 st1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct { bit st; int rnd; int tray; int n; int valid; int score; int lives; int state; } vec_t;
  typedef struct { int x; int y; int tray; int ny; int c; int m; } cw_t;
  vec_t vt [8];
  cw_t ct [14];

  initial begin
    vt[0] = '{1'b1, 100, 1000, 60,  1, 0, 3, 1};
    vt[1] = '{1'b0, 100, 164,  220, 14, 1, 3, 1};
    vt[2] = '{1'b0, 100, 400,  80,  15, 1, 2, 1};
    vt[3] = '{1'b0, 100, 400,  60,  15, 1, 1, 1};
    vt[4] = '{1'b0, 100, 400,  60,  0, 1, 0, 2};
    vt[5] = '{1'b0, 100, 400,  10,  0, 1, 0, 2};
    vt[6] = '{1'b1, 300, 1000, 0,   0, 0, 3, 1};
    vt[7] = '{1'b0, 300, 1000, 60,  1, 0, 3, 1};

    ct[0]  = '{64, 438, 20, 440, 0, 0};
    ct[1]  = '{60, 438, 20, 440, 1, 0};
    ct[2]  = '{0, 438, 20, 440, 1, 0};
    ct[3]  = '{1023, 438, 1000, 440, 1, 0};
    ct[4]  = '{959, 438, 1000, 440, 0, 0};
    ct[5]  = '{124, 438, 164, 440, 1, 0};
    ct[6]  = '{123, 438, 164, 440, 0, 0};
    ct[7]  = '{204, 438, 164, 440, 1, 0};
    ct[8]  = '{205, 438, 164, 440, 0, 0};
    ct[9]  = '{164, 436, 164, 438, 0, 0};
    ct[10] = '{164, 440, 164, 442, 0, 0};
    ct[11] = '{164, 477, 164, 479, 0, 1};
    ct[12] = '{164, 476, 164, 478, 0, 0};
    ct[13] = '{164, 439, 164, 441, 1, 0};

    m_state = 0; m_lives = 3; m_score = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin m_v[i] = 0; m_x[i] = 0; m_y[i] = 0; end

    rst = 1'b1; ft = 1'b0; st = 1'b0; rnd = '0; tray = '0;
    rst1 = 1'b1; ft1 = 1'b0; st1 = 1'b0; rnd1 = '0; tray1 = '0;
    cw_x = '0; cw_y = '0; cw_tray = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_state", gstate, 0);
    check("rst_obj_x", ox, 0);
    check("rst_pulses", {cpulse, mpulse, ovr}, 0);
    rst = 1'b0; rst1 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cw_x = 10'(ct[i].x); cw_y = 10'(ct[i].y); cw_tray = 10'(ct[i].tray);
      #1;
      check("cw_new_y", cw_ny, ct[i].ny);
      check("cw_catch", cw_c, ct[i].c);
      check("cw_miss", cw_m, ct[i].m);
    end

    for (int r = 0; r < 8; r++) begin
      rnd = 9'(vt[r].rnd);
      tray = 10'(vt[r].tray);
      if (vt[r].st) start_main();
      for (int k = 0; k < vt[r].n; k++) tick_main();
      compare_model();
      check("row_valid", valid, vt[r].valid);
      check("row_score", score, vt[r].score);
      check("row_lives", lives, vt[r].lives);
      check("row_state", gstate, vt[r].state);
    end
    check("main_no_overrun", o0, 0);

    rnd1 = 9'd7; tray1 = 10'd1000;
    start1();
    repeat (4) tick1();
    check("si1_valid_t4", valid1, 4'hF);
    tick1();
    check("si1_valid_t5", valid1, 4'hF);
    check("si1_y_t5", oy1, {10'd2, 10'd4, 10'd6, 10'd8});
    check("si1_x_t5", ox1, {4{10'd71}});
    check("si1_no_overrun", o1, 0);

    @(posedge clk); #1 ft1 = 1'b1;
    @(posedge clk); #1 ft1 = 1'b0;
    @(posedge clk); #1 ft1 = 1'b1;
    @(posedge clk); #1 ft1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("si1_overrun", o1, 1);
    check("si1_y_single_step", oy1, {10'd4, 10'd6, 10'd8, 10'd10});

    @(posedge clk); #1 rst1 = 1'b1;
    @(posedge clk); #1 rst1 = 1'b0;
    rnd1 = 9'd0; tray1 = 10'd20;
    start1();
    repeat (221) tick1();
    check("sat_no_catch", c1, 0);
    check("sat_no_miss", m1, 0);
    check("sat_y0_passed", oy1[9:0], 440);
    check("sat_valid", valid1, 4'hF);
    tray1 = 10'd24;
    tick1();
    check("edge_catch", c1, 1);
    check("edge_score", score1, 1);
    check("edge_respawn_valid", valid1, 4'hF);
    check("edge_respawn_y1", oy1[19:10], 0);

    @(posedge clk); #1 ft1 = 1'b1;
    @(posedge clk); #1 ft1 = 1'b0;
    @(posedge clk); #1 rst1 = 1'b1;
    #1;
    check("midrst_state", gstate1, 0);
    check("midrst_valid", valid1, 0);
    check("midrst_score", score1, 0);
    check("midrst_lives", lives1, 3);
    @(posedge clk); #1 rst1 = 1'b0;
    tick1();
    check("idle_tick_valid", valid1, 0);
    check("idle_tick_state", gstate1, 0);
    check("idle_tick_y", oy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
